// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge command FIFO: default word width and entry type.
package bridge_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic {
    INSTR = 1'b0,
    ADDR  = 1'b1
  } entry_type_e;

endpackage

// File: rtl/bridge_cmd_fifo.sv
// Typed command FIFO between the host and the bridge: instruction and section-address
// entries leave in push order and are popped only by the strobe matching the head type.
module bridge_cmd_fifo
  import bridge_pkg::*;
#(
  parameter int pINSTR_WIDTH = INSTR_WIDTH,
  parameter int pDEPTH       = 8
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      wr_instr_en_i,
  input  logic                      wr_addr_en_i,
  input  logic [pINSTR_WIDTH-1:0]   wr_data_i,
  output logic [pINSTR_WIDTH-1:0]   instruction_o,
  output logic                      instr_valid_o,
  output logic [pINSTR_WIDTH-1:0]   new_section_address_o,
  output logic                      addr_valid_o,
  input  logic                      rst_instr_valid_i,
  input  logic                      rst_new_address_valid_i,
  input  logic                      err_clr_i,
  output logic [$clog2(pDEPTH):0]   level_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic                      cmd_err_o,
  output logic                      underflow_o
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;

  entry_type_e               type_q [pDEPTH];
  logic [pINSTR_WIDTH-1:0]   data_q [pDEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          cmd_err_q, cmd_err_d;
  logic          underflow_q, underflow_d;

  entry_type_e               head_type;
  logic [pINSTR_WIDTH-1:0]   head_data;
  logic empty, full, head_instr, head_addr;
  logic pop_ok, push_req, push_ok, underflow_evt, overflow_evt, cmd_err_evt;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LW'(pDEPTH));
  assign head_type  = type_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign head_instr = !empty && (head_type == INSTR);
  assign head_addr  = !empty && (head_type == ADDR);

  // Each pop strobe is judged on its own against the head type.
  assign pop_ok        = (rst_instr_valid_i && head_instr) || (rst_new_address_valid_i && head_addr);
  assign underflow_evt = (rst_instr_valid_i && !head_instr) || (rst_new_address_valid_i && !head_addr);
  assign cmd_err_evt   = wr_instr_en_i && wr_addr_en_i;
  assign push_req      = wr_instr_en_i ^ wr_addr_en_i;
  assign push_ok       = push_req && (!full || pop_ok);
  assign overflow_evt  = push_req && full && !pop_ok;

  always_comb begin
    rd_ptr_d    = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d    = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d     = level_q + LW'(push_ok) - LW'(pop_ok);
    overflow_d  = overflow_evt  || (overflow_q  && !err_clr_i);
    cmd_err_d   = cmd_err_evt   || (cmd_err_q   && !err_clr_i);
    underflow_d = underflow_evt || (underflow_q && !err_clr_i);
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      cmd_err_q   <= cmd_err_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never reset; a zero level already hides every stale entry.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      type_q[wr_ptr_q] <= wr_addr_en_i ? ADDR : INSTR;
      data_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign instr_valid_o         = head_instr;
  assign addr_valid_o          = head_addr;
  assign instruction_o         = head_instr ? head_data : '0;
  assign new_section_address_o = head_addr  ? head_data : '0;
  assign level_o               = level_q;
  assign full_o                = full;
  assign empty_o               = empty;
  assign overflow_o            = overflow_q;
  assign cmd_err_o             = cmd_err_q;
  assign underflow_o           = underflow_q;

endmodule

// File: tb/tb_bridge_cmd_fifo.sv
// Scoreboard bench for bridge_cmd_fifo: directed scenarios plus random traffic against a queue model.
module tb_bridge_cmd_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic         is_addr;
    logic [W-1:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         wr_instr_en_i = 1'b0, wr_addr_en_i = 1'b0;
  logic [W-1:0] wr_data_i = '0;
  logic [W-1:0] instruction_o, new_section_address_o;
  logic         instr_valid_o, addr_valid_o;
  logic         rst_instr_valid_i = 1'b0, rst_new_address_valid_i = 1'b0, err_clr_i = 1'b0;
  logic [3:0]   level_o;
  logic         full_o, empty_o, overflow_o, cmd_err_o, underflow_o;

  bridge_cmd_fifo #(.pINSTR_WIDTH(W), .pDEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i),
    .wr_instr_en_i(wr_instr_en_i), .wr_addr_en_i(wr_addr_en_i), .wr_data_i(wr_data_i),
    .instruction_o(instruction_o), .instr_valid_o(instr_valid_o),
    .new_section_address_o(new_section_address_o), .addr_valid_o(addr_valid_o),
    .rst_instr_valid_i(rst_instr_valid_i), .rst_new_address_valid_i(rst_new_address_valid_i),
    .err_clr_i(err_clr_i), .level_o(level_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .cmd_err_o(cmd_err_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   in_reset = 1'b1;
  ent_t m_q[$];
  ent_t sb_q[$];
  bit   m_ovf = 0, m_cerr = 0, m_und = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue; a pop needs a non-empty queue whose front type matches the strobe.
  task automatic step(input bit wi, input bit wa, input logic [W-1:0] d,
                      input bit pi, input bit pa, input bit clr);
    bit front_instr, front_addr, pop_ok, und, cerr, pushing, room, ovf;
    wr_instr_en_i = wi; wr_addr_en_i = wa; wr_data_i = d;
    rst_instr_valid_i = pi; rst_new_address_valid_i = pa; err_clr_i = clr;
    front_instr = (m_q.size() > 0) && !m_q[0].is_addr;
    front_addr  = (m_q.size() > 0) &&  m_q[0].is_addr;
    pop_ok  = (pi && front_instr) || (pa && front_addr);
    und     = (pi && !front_instr) || (pa && !front_addr);
    cerr    = wi && wa;
    pushing = (wi != wa);
    room    = (m_q.size() < DEPTH) || pop_ok;
    ovf     = pushing && !room;
    @(posedge clk); #1;
    if (pop_ok) void'(m_q.pop_front());
    if (pushing && room) begin
      m_q.push_back({wa, d});
      sb_q.push_back({wa, d});
    end
    m_ovf  = ovf  || (m_ovf  && !clr);
    m_cerr = cerr || (m_cerr && !clr);
    m_und  = und  || (m_und  && !clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic push(input bit is_addr, input logic [W-1:0] d);
    step(!is_addr, is_addr, d, 0, 0, 0);
  endtask

  task automatic pop_head();
    if (m_q.size() > 0) step(0, 0, '0, !m_q[0].is_addr, m_q[0].is_addr, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_empty"}, empty_o, 1);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_valids"}, {instr_valid_o, addr_valid_o}, 0);
    chk({tag, "_data"}, {instruction_o, new_section_address_o}, 0);
    chk({tag, "_flags"}, {overflow_o, cmd_err_o, underflow_o}, 0);
  endtask

  // Monitor: cycle state against the model, and each consumed head against the scoreboard.
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("level", level_o, m_q.size());
      chk("empty", empty_o, m_q.size() == 0);
      chk("full", full_o, m_q.size() == DEPTH);
      chk("flags", {overflow_o, cmd_err_o, underflow_o}, {m_ovf, m_cerr, m_und});
      chk("instr_valid", instr_valid_o, (m_q.size() > 0) && !m_q[0].is_addr);
      chk("addr_valid", addr_valid_o, (m_q.size() > 0) && m_q[0].is_addr);
      chk("instruction", instruction_o,
          ((m_q.size() > 0) && !m_q[0].is_addr) ? m_q[0].data : '0);
      chk("section_addr", new_section_address_o,
          ((m_q.size() > 0) && m_q[0].is_addr) ? m_q[0].data : '0);
      if ((rst_instr_valid_i && instr_valid_o) || (rst_new_address_valid_i && addr_valid_o)) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          ent_t e;
          e = sb_q.pop_front();
          chk("sb_type", addr_valid_o, e.is_addr);
          chk("sb_data", addr_valid_o ? new_section_address_o : instruction_o, e.data);
        end
      end
    end
  end

  initial begin
    bit wi, wa, pi, pa;
    int r;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset_i = 0;
    in_reset = 0;
    idle(2);

    // Single instruction visible the cycle after the push.
    push(0, 32'h0000_0013);
    chk("first_instr", instruction_o, 32'h0000_0013);
    idle(1);
    pop_head();

    // Address first, then two instructions; a wrong-type pop must only flag underflow.
    push(1, 32'h0001_0000);
    push(0, 32'hAAAA_0001);
    push(0, 32'hAAAA_0002);
    step(0, 0, '0, 1, 0, 0);
    chk("mismatch_level", level_o, 3);
    chk("mismatch_underflow", underflow_o, 1);
    step(0, 0, '0, 0, 0, 1);
    pop_head(); pop_head(); pop_head();
    step(0, 0, '0, 0, 1, 0);
    idle(1);
    step(0, 0, '0, 0, 0, 1);

    // Nine pushes into eight slots: last one dropped.
    for (int i = 0; i < 9; i++) push($urandom_range(0, 1), $urandom);
    chk("ovf_full", full_o, 1);
    chk("ovf_flag", overflow_o, 1);
    step(0, 0, '0, 0, 0, 1);

    // Push with matching pop while full: level holds, pointers wrap.
    for (int i = 0; i < 12; i++) begin
      wa = $urandom_range(0, 1);
      step(!wa, wa, $urandom, !m_q[0].is_addr, m_q[0].is_addr, 0);
    end
    chk("pp_level", level_o, 8);
    chk("pp_ovf", overflow_o, 0);
    while (m_q.size() > 0) pop_head();

    // Both push strobes: nothing pushed, cmd_err set; clear, then clear racing a new error.
    push(0, 32'h1111_2222);
    step(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("cmderr_flag", cmd_err_o, 1);
    chk("cmderr_level", level_o, 1);
    step(0, 0, '0, 0, 0, 1);
    step(1, 1, 32'hDEAD_BEEF, 0, 0, 1);
    chk("cmderr_wins", cmd_err_o, 1);
    step(0, 0, '0, 0, 0, 1);
    pop_head();

    // Reset mid-stream discards everything immediately.
    for (int i = 0; i < 5; i++) push($urandom_range(0, 1), $urandom);
    step(0, 0, '0, 0, 1, 0);
    in_reset = 1;
    reset_i = 1;
    #1 check_reset_outputs("midreset");
    m_q.delete(); sb_q.delete();
    m_ovf = 0; m_cerr = 0; m_und = 0;
    rst_new_address_valid_i = 0;
    @(posedge clk); #1;
    reset_i = 0;
    in_reset = 0;
    push(1, 32'h0002_0000);
    push(0, 32'h0000_0093);
    pop_head(); pop_head();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      wi = (r <= 3) || (r == 8);
      wa = ((r >= 4) && (r <= 7)) || (r == 8);
      r = $urandom_range(0, 9);
      pi = (r <= 3);
      pa = (r >= 4) && (r <= 7);
      step(wi, wa, $urandom, pi, pa, $urandom_range(0, 15) == 0);
    end
    while (m_q.size() > 0) pop_head();
    step(0, 0, '0, 0, 0, 1);
    idle(2);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
